uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among NUM_REQ byte requesters. It accepts one byte at a time from the winning requester and launches it with a single-cycle valid pulse. It then tracks the transmitter's active/done status and enforces a programmable idle gap before the next launch. It sits between the host-side byte producers and the uart_tx instance, whose i_tx_dv, i_tx_byte, o_tx_active and o_tx_done it drives and monitors.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- GAP_CLKS, 0: extra idle clocks inserted after each frame before the next launch; legal range 0..255.
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_req  in  NUM_REQ  per-requester request; bit n high = byte pending.
- i_req_byte  in  8*NUM_REQ  requester n's byte on bits [8n+7:8n].
- o_ack  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester n accepted.
- o_done  out  NUM_REQ  one-hot, 1-cycle pulse: requester n's frame finished.
- o_tx_dv  out  1  to uart_tx i_tx_dv; 1-cycle launch pulse.
- o_tx_byte  out  8  to uart_tx i_tx_byte; held stable from launch until the frame ends.
- i_tx_active  in  1  from uart_tx o_tx_active.
- i_tx_done  in  1  from uart_tx o_tx_done.
- o_busy  out  1  high in every state except S_IDLE.

## Operation
- States: S_IDLE, S_LAUNCH, S_WAIT_ACTIVE, S_WAIT_DONE, S_WAIT_CLEAR, S_GAP.
- S_IDLE
  - Requires i_tx_active=0 and i_tx_done=0.
  - If any i_req bit is set, pick the winner round-robin. The search starts at index last_grant+1 modulo NUM_REQ; last_grant resets to NUM_REQ-1, so index 0 has first priority after reset.
  - Register the winner's byte into o_tx_byte, update last_grant, then go to S_LAUNCH.
- S_LAUNCH: o_tx_dv=1 and o_ack[winner]=1 for exactly this cycle, then go to S_WAIT_ACTIVE.
- S_WAIT_ACTIVE: go to S_WAIT_DONE on i_tx_active=1.
- S_WAIT_DONE: on i_tx_done=1, pulse o_done[winner] for one cycle and go to S_WAIT_CLEAR.
- S_WAIT_CLEAR: wait for i_tx_done=0. The transmitter ignores valid during its cleanup cycle, so no launch is allowed before done clears.
- On leaving S_WAIT_CLEAR:
  - GAP_CLKS=0: go straight to S_IDLE.
  - Otherwise go to S_GAP, count GAP_CLKS cycles (8-bit down-counter), then go to S_IDLE.
- Requester rules:
  - Hold i_req high and i_req_byte stable until o_ack.
  - Deassertion before o_ack withdraws the request with no side effects.
  - Request bits sampled in any state other than S_IDLE are ignored.
- Fairness: a requester that keeps i_req asserted waits at most NUM_REQ-1 frames.

## Timing
- Reset values:
  - State S_IDLE; o_ack=0, o_done=0, o_tx_dv=0, o_tx_byte=8'h00, o_busy=0.
  - last_grant=NUM_REQ-1; gap counter=0.
- Latency: request sampled in S_IDLE at edge k gives o_tx_dv=1 and o_ack=1 during cycle k+1.
- Back-to-back with GAP_CLKS=0: the next o_tx_dv occurs 2 cycles after i_tx_done falls (through S_IDLE, then S_LAUNCH).
- Reset mid-frame: the controller returns to S_IDLE immediately. The transmitter has no reset, so no launch occurs until i_tx_active=0 and i_tx_done=0. An in-flight frame completes with no o_done pulse.
- i_tx_active never rising after launch leaves the controller in S_WAIT_ACTIVE until i_reset; no timeout.
- At most one bit of o_ack and of o_done is ever set; the two never pulse for the same grant in the same cycle.

## Structure
- Shared package uart_pkg:
  - State encoding constants for the six states.
  - Width constant for the gap counter.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: request vector, last_grant index.
  - Outputs: one-hot grant, its index, and any-grant flag.
  - Purely combinational; last_grant is registered in the parent.

## Test plan
- Single request: NUM_REQ=4, CLKS_PER_BIT=4, i_req=4'b0100, byte 8'hA5 → o_ack[2] one cycle later with o_tx_dv. The serial line carries start bit 0, then A5 LSB-first, then stop bit 1. o_done[2] pulses once.
- All requesting: i_req=4'b1111 held, byte n = 8'h10+n, re-asserted after each ack → acks in order 0,1,2,3,0. Serial bytes 10,11,12,13,10. No dv pulse ever falls while i_tx_done=1.
- Gap: GAP_CLKS=5, two requesters → exactly 5+2 cycles from i_tx_done falling to the next o_tx_dv; 2 cycles with GAP_CLKS=0.
- Withdrawal: i_req[1] pulsed for one cycle while busy, then dropped → no o_ack[1] and no extra frame.
- Reset mid-data-bit: i_reset for one cycle → all outputs at reset values. A pending request launches only after uart_tx returns idle with done cleared. No o_done for the aborted grant.
- Fairness after reset: i_req=4'b1001 → first grant index 0, then 3, then 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: controller state encoding
// and the width of the inter-frame gap counter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LAUNCH      = 3'd1,
    S_WAIT_ACTIVE = 3'd2,
    S_WAIT_DONE   = 3'd3,
    S_WAIT_CLEAR  = 3'd4,
    S_GAP         = 3'd5
  } state_t;

  localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req;
  logic [8*NUM_REQ-1:0] i_req_byte;
  logic [NUM_REQ-1:0]   o_ack;
  logic [NUM_REQ-1:0]   o_done;
  logic                 o_tx_dv;
  logic [7:0]           o_tx_byte;
  logic                 i_tx_active;
  logic                 i_tx_done;
  logic                 o_busy;

  modport slave (
    input  i_req, i_req_byte, i_tx_active, i_tx_done,
    output o_ack, o_done, o_tx_dv, o_tx_byte, o_busy
  );

  modport master (
    output i_req, i_req_byte, i_tx_active, i_tx_done,
    input  o_ack, o_done, o_tx_dv, o_tx_byte, o_busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the slot after the
// previous winner and returns the first pending request.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters: round-robin grant,
// single-cycle launch, frame tracking and an optional idle gap between frames.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int GAP_CLKS = 0
) (
  input logic              i_clock,
  input logic              i_reset,
  uart_tx_arbiter_if.slave io_bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    GAP_CNT_W'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_last;
  logic [NUM_REQ-1:0]     r_win_oh;
  logic [NUM_REQ-1:0]     r_ack;
  logic [NUM_REQ-1:0]     r_done;
  logic                   r_tx_dv;
  logic [7:0]             r_tx_byte;
  logic [GAP_CNT_W-1:0]   r_gap_cnt;

  logic [NUM_REQ-1:0]     w_grant;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_any;
  logic                   w_tx_idle;
  logic [7:0]             w_win_byte;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (io_bus.i_req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The transmitter has no reset, so a launch also waits out any frame left over from before reset.
  assign w_tx_idle = !io_bus.i_tx_active && !io_bus.i_tx_done;

  always_comb begin
    w_win_byte = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (w_grant[n]) w_win_byte = io_bus.i_req_byte[8*n +: 8];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_last    <= IDX_W'(NUM_REQ - 1);
      r_win_oh  <= '0;
      r_ack     <= '0;
      r_done    <= '0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_gap_cnt <= '0;
    end else begin
      r_ack   <= '0;
      r_done  <= '0;
      r_tx_dv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tx_idle && w_any) begin
            r_tx_byte <= w_win_byte;
            r_last    <= w_idx;
            r_win_oh  <= w_grant;
            r_ack     <= w_grant;
            r_tx_dv   <= 1'b1;
            r_state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_WAIT_ACTIVE;
        S_WAIT_ACTIVE: begin
          if (io_bus.i_tx_active) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (io_bus.i_tx_done) begin
            r_done  <= r_win_oh;
            r_state <= S_WAIT_CLEAR;
          end
        end
        // Valid is ignored during the transmitter's cleanup cycle, so hold off until done drops.
        S_WAIT_CLEAR: begin
          if (!io_bus.i_tx_done) begin
            if (GAP_CLKS == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_gap_cnt <= GAP_LOAD;
              r_state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) r_state <= S_IDLE;
          else                 r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.o_ack     = r_ack;
  assign io_bus.o_done    = r_done;
  assign io_bus.o_tx_dv   = r_tx_dv;
  assign io_bus.o_tx_byte = r_tx_byte;
  assign io_bus.o_busy    = (r_state != S_IDLE);

endmodule
